// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS definitions: comma patterns, K28.5 code-groups and
// the aligner state encoding.
package pcs_pkg;

  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  function automatic logic is_comma(input logic [6:0] bits);
    return (bits == COMMA_POS) || (bits == COMMA_NEG);
  endfunction

endpackage

// File: rtl/pcs_comma_detect.sv
// Combinational comma search over all ten bit offsets of a 20-bit window;
// reports every matching offset and the lowest one.
module pcs_comma_detect
  import pcs_pkg::*;
(
  input  logic [19:0] window,
  output logic [9:0]  match,
  output logic [3:0]  first_idx,
  output logic        any_match
);

  for (genvar k = 0; k < 10; k++) begin : g_offset
    assign match[k] = is_comma(window[19-k -: 7]);
  end

  // Scan downwards so the lowest matching offset is the one left standing.
  always_comb begin
    first_idx = 4'd0;
    any_match = |match;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) first_idx = 4'(k);
    end
  end

endmodule

// File: rtl/pcs_comma_aligner.sv
// Receive-side code-group aligner: locks to the K28.5 comma offset and
// re-aligns after MISALIGN_LIMIT consecutive commas at another offset.
module pcs_comma_aligner
  import pcs_pkg::*;
#(
  parameter int MISALIGN_LIMIT = 3
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic       power,
  input  logic [9:0] raw_code_group,
  output logic [9:0] rx_code_group,
  output logic       code_valid,
  output logic       comma_det,
  output logic [3:0] align_offset,
  output logic       realign
);

  localparam logic [3:0] LIMIT = 4'(MISALIGN_LIMIT);

  logic [9:0]   r0, r1;
  logic [19:0]  window;
  logic [9:0]   match;
  logic [3:0]   first_idx;
  logic         any_match;

  align_state_t state, state_next;
  logic [3:0]   lock_offset, offset_next;
  logic [3:0]   miss_cnt, miss_next;
  logic [3:0]   cand, cand_next;
  logic         realign_next;

  assign window = {r1, r0};

  pcs_comma_detect u_detect (
    .window    (window),
    .match     (match),
    .first_idx (first_idx),
    .any_match (any_match)
  );

  // The deserializer pipeline keeps shifting even while power is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r0 <= '0;
      r1 <= '0;
    end else begin
      r0 <= raw_code_group;
      r1 <= r0;
    end
  end

  always_comb begin
    state_next   = state;
    offset_next  = lock_offset;
    miss_next    = miss_cnt;
    cand_next    = cand;
    realign_next = 1'b0;
    if (!power) begin
      state_next  = HUNT;
      offset_next = 4'd0;
      miss_next   = 4'd0;
      cand_next   = 4'd0;
    end else if (state == HUNT) begin
      if (any_match) begin
        state_next  = LOCKED;
        offset_next = first_idx;
        miss_next   = 4'd0;
      end
    end else if (match[lock_offset]) begin
      miss_next = 4'd0;
    end else if (any_match) begin
      // A new stray offset restarts the run of misaligned commas.
      cand_next = first_idx;
      if (first_idx != cand) miss_next = 4'd1;
      else if (miss_cnt < LIMIT) miss_next = miss_cnt + 4'd1;
      if (miss_next >= LIMIT) begin
        offset_next  = first_idx;
        miss_next    = 4'd0;
        realign_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= HUNT;
      lock_offset   <= '0;
      miss_cnt      <= '0;
      cand          <= '0;
      rx_code_group <= '0;
      code_valid    <= 1'b0;
      comma_det     <= 1'b0;
      align_offset  <= '0;
      realign       <= 1'b0;
    end else begin
      state       <= state_next;
      lock_offset <= offset_next;
      miss_cnt    <= miss_next;
      cand        <= cand_next;
      realign     <= realign_next;
      // Outputs follow the next-state offset so the locking comma itself is delivered.
      if (state_next == LOCKED) begin
        rx_code_group <= 10'(window >> (10 - offset_next));
        code_valid    <= 1'b1;
        comma_det     <= match[offset_next];
        align_offset  <= offset_next;
      end else begin
        rx_code_group <= '0;
        code_valid    <= 1'b0;
        comma_det     <= 1'b0;
        align_offset  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pcs_comma_aligner.sv
// Randomized and directed bench for pcs_comma_aligner against a bit-stream
// reference model of the comma alignment rules.
module tb_pcs_comma_aligner;

  localparam int LIMIT = 3;
  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;
  localparam logic [9:0] D16_2 = 10'b1001000101;

  logic       clock = 1'b0;
  logic       reset;
  logic       power;
  logic [9:0] raw_code_group;
  logic [9:0] rx_code_group;
  logic       code_valid;
  logic       comma_det;
  logic [3:0] align_offset;
  logic       realign;

  int compared = 0;
  int mismatched = 0;

  logic bitq[$];

  logic [9:0] m_r0, m_r1;
  bit         m_locked;
  int         m_off, m_cnt, m_cand;
  logic [9:0] e_rx;
  logic       e_valid, e_det, e_realign;
  logic [3:0] e_off;

  pcs_comma_aligner #(.MISALIGN_LIMIT(LIMIT)) dut (
    .clock          (clock),
    .reset          (reset),
    .power          (power),
    .raw_code_group (raw_code_group),
    .rx_code_group  (rx_code_group),
    .code_valid     (code_valid),
    .comma_det      (comma_det),
    .align_offset   (align_offset),
    .realign        (realign)
  );

  always #5 clock = ~clock;

  function automatic logic [16:0] dut_vec();
    return {rx_code_group, code_valid, comma_det, align_offset, realign};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {e_rx, e_valid, e_det, e_off, e_realign};
  endfunction

  task automatic model_reset();
    m_r0 = '0; m_r1 = '0; m_locked = 0; m_off = 0; m_cnt = 0; m_cand = 0;
    e_rx = '0; e_valid = 0; e_det = 0; e_off = '0; e_realign = 0;
  endtask

  // One clock edge of the alignment rules applied to the bit window seen at that edge.
  task automatic model_edge(input logic [9:0] word);
    logic [19:0] w;
    logic [9:0]  hit;
    logic [6:0]  seg;
    int          first;
    w = {m_r1, m_r0};
    m_r1 = m_r0;
    m_r0 = word;
    e_realign = 0;
    if (!power) begin
      m_locked = 0; m_off = 0; m_cnt = 0; m_cand = 0;
      e_rx = '0; e_valid = 0; e_det = 0; e_off = '0;
      return;
    end
    hit = '0;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      seg = 7'(w >> (13 - k));
      if (seg == 7'b0011111 || seg == 7'b1100000) begin
        hit[k] = 1'b1;
        if (first < 0) first = k;
      end
    end
    if (!m_locked) begin
      if (first >= 0) begin
        m_locked = 1; m_off = first; m_cnt = 0;
      end
    end else if (hit[m_off]) begin
      m_cnt = 0;
    end else if (first >= 0) begin
      m_cnt = (first == m_cand) ? m_cnt + 1 : 1;
      m_cand = first;
      if (m_cnt >= LIMIT) begin
        m_off = first; m_cnt = 0; e_realign = 1;
      end
    end
    if (m_locked) begin
      e_rx = 10'(w >> (10 - m_off)); e_valid = 1; e_det = hit[m_off]; e_off = 4'(m_off);
    end else begin
      e_rx = '0; e_valid = 0; e_det = 0; e_off = '0;
    end
  endtask

  task automatic push_group(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  task automatic push_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      push_group(K_RDN);
      push_group(D16_2);
    end
  endtask

  task automatic push_slip(input int n);
    for (int i = 0; i < n; i++) bitq.push_back((i % 2) == 0);
  endtask

  task automatic step();
    logic [9:0] word;
    for (int i = 9; i >= 0; i--) word[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
    raw_code_group = word;
    @(posedge clock);
    model_edge(word);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    power = 1'b1;
    raw_code_group = '0;
    bitq.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    compared++;
    if (dut_vec() !== 17'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got %h, expected %h", dut_vec(), 17'd0);
    end
  endtask

  task automatic test_aligned();
    apply_reset();
    push_pairs(4);
    for (int c = 1; c <= 8; c++) begin
      step();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL aligned cycle %0d: got %h, expected %h", c, dut_vec(), exp_vec());
      end
      if (c == 3) begin
        compared++;
        if ({rx_code_group, code_valid, comma_det, align_offset} !== {K_RDN, 1'b1, 1'b1, 4'd0}) begin
          mismatched++;
          $display("[TB] FAIL aligned_first_lock: got rx=%b v=%b d=%b off=%0d, expected rx=%b v=1 d=1 off=0",
                   rx_code_group, code_valid, comma_det, align_offset, K_RDN);
        end
      end
      if (c == 4) begin
        compared++;
        if ({rx_code_group, comma_det} !== {D16_2, 1'b0}) begin
          mismatched++;
          $display("[TB] FAIL aligned_d16_2: got rx=%b d=%b, expected rx=%b d=0", rx_code_group, comma_det, D16_2);
        end
      end
    end
  endtask

  task automatic test_delayed();
    int pulses = 0;
    apply_reset();
    push_slip(3);
    push_pairs(4);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (realign) pulses++;
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL delayed cycle %0d: got %h, expected %h", c, dut_vec(), exp_vec());
      end
      if (c == 3) begin
        compared++;
        if ({rx_code_group, code_valid, align_offset} !== {K_RDN, 1'b1, 4'd3}) begin
          mismatched++;
          $display("[TB] FAIL delayed_lock: got rx=%b v=%b off=%0d, expected rx=%b v=1 off=3",
                   rx_code_group, code_valid, align_offset, K_RDN);
        end
      end
      if (c == 4) begin
        compared++;
        if (rx_code_group !== D16_2) begin
          mismatched++;
          $display("[TB] FAIL delayed_d16_2: got %b, expected %b", rx_code_group, D16_2);
        end
      end
    end
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("[TB] FAIL delayed_no_realign: got %0d pulses, expected 0", pulses);
    end
  endtask

  task automatic test_realign();
    int pulses = 0;
    logic [10:0] at_pulse = '0;
    apply_reset();
    push_pairs(3);
    push_slip(5);
    push_pairs(5);
    for (int c = 1; c <= 18; c++) begin
      step();
      if (realign) begin
        pulses++;
        at_pulse = {rx_code_group, comma_det};
      end
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL realign cycle %0d: got %h, expected %h", c, dut_vec(), exp_vec());
      end
    end
    compared++;
    if ({pulses[3:0], align_offset, at_pulse} !== {4'd1, 4'd5, K_RDN, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL realign_pulse: got pulses=%0d off=%0d at_pulse=%b, expected pulses=1 off=5 at_pulse=%b1",
               pulses, align_offset, at_pulse, K_RDN);
    end
  endtask

  task automatic test_interrupted_run();
    int pulses = 0;
    apply_reset();
    push_pairs(3);
    push_slip(5);
    push_pairs(2);
    push_slip(5);
    push_pairs(1);
    push_slip(5);
    push_pairs(2);
    repeat (4) push_group(D16_2);
    for (int c = 1; c <= 22; c++) begin
      step();
      if (realign) pulses++;
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL interrupted cycle %0d: got %h, expected %h", c, dut_vec(), exp_vec());
      end
    end
    compared++;
    if ({pulses[3:0], align_offset} !== {4'd0, 4'd0}) begin
      mismatched++;
      $display("[TB] FAIL interrupted_run: got pulses=%0d off=%0d, expected pulses=0 off=0", pulses, align_offset);
    end
  endtask

  task automatic test_alternating();
    int pulses = 0;
    apply_reset();
    push_pairs(3);
    push_slip(5);
    repeat (4) begin
      push_pairs(1);
      push_slip(2);
      push_pairs(1);
      push_slip(8);
    end
    for (int c = 1; c <= 27; c++) begin
      step();
      if (realign) pulses++;
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL alternating cycle %0d: got %h, expected %h", c, dut_vec(), exp_vec());
      end
    end
    compared++;
    if ({pulses[3:0], align_offset, code_valid} !== {4'd0, 4'd0, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL alternating_hold: got pulses=%0d off=%0d v=%b, expected pulses=0 off=0 v=1",
               pulses, align_offset, code_valid);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    push_pairs(8);
    repeat (6) step();
    #3;
    reset = 1'b1;
    #1;
    compared++;
    if (dut_vec() !== 17'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got %h, expected %h", dut_vec(), 17'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    for (int c = 1; c <= 8; c++) begin
      step();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL relock cycle %0d: got %h, expected %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_power();
    apply_reset();
    push_pairs(8);
    repeat (5) step();
    power = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      compared++;
      if (dut_vec() !== 17'd0) begin
        mismatched++;
        $display("[TB] FAIL power_off cycle %0d: got %h, expected %h", c, dut_vec(), 17'd0);
      end
    end
    power = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL power_on cycle %0d: got %h, expected %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 1; c <= 600; c++) begin
      while (bitq.size() < 20) begin
        case ($urandom_range(0, 9))
          0, 1, 2: push_group($urandom_range(0, 1) ? K_RDP : K_RDN);
          3:       repeat ($urandom_range(1, 9)) bitq.push_back(1'($urandom_range(0, 1)));
          default: push_group(10'($urandom));
        endcase
      end
      power = ($urandom_range(0, 49) != 0);
      step();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL random cycle %0d: got %h, expected %h", c, dut_vec(), exp_vec());
      end
    end
    power = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    power = 1'b1;
    raw_code_group = '0;
    model_reset();
    test_reset();
    test_aligned();
    test_delayed();
    test_realign();
    test_interrupted_run();
    test_alternating();
    test_reset_midstream();
    test_power();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pcs_comma_aligner.md
# pcs_comma_aligner

Receive-side code-group aligner for the 1000BASE-X PCS. It takes unaligned 10-bit words from the deserializer and searches all 10 bit offsets for the comma in /K28.5/. Once it locks to the comma offset, it delivers word-aligned code-groups on `rx_code_group` to the synchronization block. It also tracks comma position over time and re-aligns after persistent misalignment.

## Interface
- `MISALIGN_LIMIT`, default 3: consecutive commas at a non-locked offset that force a re-align (range 1..15).
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `power`  in  1  block enable; low forces HUNT and reset output values.
- `raw_code_group`  in  10  deserializer word; bit 9 received first, arbitrary bit offset.
- `rx_code_group`  out  10  aligned code-group, bit 9 = `a`, bit 0 = `j`.
- `code_valid`  out  1  high while LOCKED; qualifies `rx_code_group`.
- `comma_det`  out  1  current `rx_code_group` contains a comma at the locked offset.
- `align_offset`  out  4  current locked offset, 0..9.
- `realign`  out  1  one-cycle pulse when the offset changes while LOCKED.

## Operation
- Pipeline:
  - `r0 <= raw_code_group`, then `r1 <= r0`.
  - Window `w = {r1, r0}` is 20 bits; `w[19]` is the oldest bit.
- Candidate word at offset k is `w[19-k:10-k]`.
- Comma at k: `w[19-k:13-k]` equals 7'b0011111 or 7'b1100000.
- If several offsets match in one cycle, the lowest k wins.
- States:
  - HUNT:
    - `code_valid=0`.
    - Comma at any k → load `align_offset=k` and go to LOCKED.
    - No `realign` pulse on this first lock.
  - LOCKED:
    - Comma at the locked offset → clear `miss_cnt`.
    - Comma only at other offset j → `miss_cnt++` and remember j. If j differs from the previously remembered j, `miss_cnt` restarts at 1.
    - When `miss_cnt` reaches `MISALIGN_LIMIT` → `align_offset=j`, `miss_cnt=0`, pulse `realign`.
    - No comma → no change.
- Output register captures `w` at the next-state offset. The comma that triggers a lock or re-align is itself output with `code_valid=1` and `comma_det=1`.
- Reset: all outputs 0, state HUNT, `miss_cnt=0`, `r0=r1=0`.
- Reset asserted mid-stream clears immediately (asynchronous). The first lock needs a fresh comma.
- `power=0`:
  - Synchronously, next edge: state HUNT, counters cleared, outputs at reset values.
  - `r0`/`r1` keep shifting, so a comma can be detected on the first edge after `power` rises.
- `miss_cnt` is 4 bits and saturates at `MISALIGN_LIMIT`; no wrap.

## Timing
- Latency: a word sampled at edge n reaches `rx_code_group` after edge n+2 (offset 0). For offset k>0, the output contains the tail of word n and the head of word n+1, also valid after edge n+2.
- `code_valid`, `comma_det`, `align_offset`, and `realign` are registered alongside `rx_code_group`, in the same cycle.
- One word is accepted per clock; there is no backpressure.
- Lock-acquisition latency is 2 cycles from the comma word's sample edge.

## Structure
- Shared package `pcs_pkg` holds:
  - `COMMA_POS` = 7'b0011111 and `COMMA_NEG` = 7'b1100000.
  - `K28_5_RDN` = 10'b0011111010 and `K28_5_RDP` = 10'b1100000101.
  - The aligner state encoding (HUNT, LOCKED).
- Sub-module `pcs_comma_detect` is combinational:
  - Input: 20-bit window.
  - Outputs: 10-bit per-offset match vector, plus the lowest-match index with an any-match flag.

## Test plan
- Aligned /I2/ stream (0011111010, 1001000101 repeating) after reset → after edge 3, `rx_code_group`=0011111010, `code_valid=1`, `comma_det=1`, `align_offset=0`; D16.2 follows on the next cycle.
- Same bitstream delayed by 3 bits → `align_offset=3`, output words identical to the aligned case, `realign` stays 0.
- Locked at offset 0, then 3 commas at offset 5 (`MISALIGN_LIMIT=3`) → on the 3rd, `align_offset=5` and `realign` is one cycle high. Check two at 5, one at 0, two at 5 → no re-align.
- Alternating commas at offsets 5 and 7 while locked at 0 → `miss_cnt` never reaches 3; `align_offset` stays 0.
- `reset` pulsed mid-stream while LOCKED → outputs 0 immediately; re-lock 2 cycles after the next comma.
- `power` low for 4 cycles while LOCKED → `code_valid=0` and outputs 0 from the next edge. After `power` rises, lock occurs on the first comma.
